word_assembler: RTL

Collects the per-gesture letter codes from the glove classifier, debounces them, packs accepted letters into a 120-bit word (24 × 5-bit slots), and hands the word to the dictionary stage with a start pulse. Sits directly upstream of the dictionary corrector. It holds the word stable until the dictionary signals finish, then clears for the next word.

---
 rtl/word_assembler_if.sv | 26 ++
 rtl/word_assembler.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/word_assembler_if.sv
// Classifier/dictionary-facing signal bundle for word_assembler.
// master drives the sample/handshake inputs; slave is the assembler itself.
interface word_assembler_if #(
   parameter int MAX_LEN = 24
);
   logic                   i_valid;
   logic [4:0]             i_letter;
   logic                   i_end;
   logic                   i_dict_finish;
   logic                   o_start;
   logic [MAX_LEN*5-1:0]   o_word;
   logic [4:0]             o_len;
   logic                   o_overflow;
   logic                   o_busy;
   logic [1:0]             o_state;

   modport master (
      output i_valid, i_letter, i_end, i_dict_finish,
      input  o_start, o_word, o_len, o_overflow, o_busy, o_state
   );

   modport slave (
      input  i_valid, i_letter, i_end, i_dict_finish,
      output o_start, o_word, o_len, o_overflow, o_busy, o_state
   );
endinterface

// File: rtl/word_assembler.sv
// Debounces classifier letter codes, packs accepted letters into a word and hands it
// to the dictionary stage. Optional feature macro: WORD_BACKSPACE_EN (code 27 deletes).
module word_assembler #(
   parameter int HOLD    = 4,
   parameter int MAX_LEN = 24
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   word_assembler_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_SEND    = 2'd2,
      S_WAIT    = 2'd3
   } state_t;

   localparam int         WW     = MAX_LEN * 5;
   localparam logic [3:0] HOLD_C = 4'(HOLD);
   localparam logic [4:0] MAX_C  = 5'(MAX_LEN);

   state_t          state_q, state_d;
   logic [4:0]      cand_q, cand_d;
   logic [3:0]      run_q, run_d;
   logic            locked_q, locked_d;
   logic [WW-1:0]   word_q, word_d;
   logic [4:0]      len_q, len_d;
   logic            ovf_q, ovf_d;
   logic            start_q, start_d;
   logic            busy_q, busy_d;
   logic            sample;

   always_comb begin
      state_d  = state_q;
      cand_d   = cand_q;
      run_d    = run_q;
      locked_d = locked_q;
      word_d   = word_q;
      len_d    = len_q;
      ovf_d    = ovf_q;
      sample   = 1'b0;

      case (state_q)
         S_IDLE: begin
            word_d   = '0;
            len_d    = '0;
            run_d    = '0;
            ovf_d    = 1'b0;
            locked_d = 1'b0;
            if (bus.i_valid && bus.i_letter != 5'd0 && bus.i_letter <= 5'd26) begin
               state_d = S_COLLECT;
               sample  = 1'b1;
            end
         end
         S_COLLECT: begin
            if (bus.i_end) begin
               state_d = (len_q != 5'd0) ? S_SEND : S_IDLE;
            end else if (bus.i_valid) begin
               sample = 1'b1;
            end
         end
         S_SEND: state_d = S_WAIT;
         S_WAIT: begin
            if (bus.i_dict_finish) begin
               state_d = S_IDLE;
               word_d  = '0;
               len_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A differing code restarts the run and releases the lock on the old candidate.
      if (sample) begin
         if (state_q == S_COLLECT && bus.i_letter == cand_q) begin
            run_d = (run_q == HOLD_C) ? run_q : run_q + 4'd1;
         end else begin
            cand_d   = bus.i_letter;
            run_d    = 4'd1;
            locked_d = 1'b0;
         end
         if (run_d == HOLD_C && !locked_d) begin
            locked_d = 1'b1;
            if (cand_d != 5'd0 && cand_d <= 5'd26) begin
               if (len_q == MAX_C) begin
                  ovf_d = 1'b1;
               end else begin
                  for (int k = 0; k < MAX_LEN; k++) begin
                     if (5'(k) == len_q) word_d[k*5 +: 5] = cand_d;
                  end
                  len_d = len_q + 5'd1;
               end
            end
`ifdef WORD_BACKSPACE_EN
            else if (cand_d == 5'd27) begin
               ovf_d = 1'b0;
               if (len_q != 5'd0) begin
                  for (int k = 0; k < MAX_LEN; k++) begin
                     if (5'(k) + 5'd1 == len_q) word_d[k*5 +: 5] = 5'd0;
                  end
                  len_d = len_q - 5'd1;
               end
            end
`endif
         end
      end

      start_d = (state_d == S_SEND);
      busy_d  = (state_d == S_SEND) || (state_d == S_WAIT);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= S_IDLE;
         cand_q   <= '0;
         run_q    <= '0;
         locked_q <= 1'b0;
         word_q   <= '0;
         len_q    <= '0;
         ovf_q    <= 1'b0;
         start_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cand_q   <= cand_d;
         run_q    <= run_d;
         locked_q <= locked_d;
         word_q   <= word_d;
         len_q    <= len_d;
         ovf_q    <= ovf_d;
         start_q  <= start_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.o_start    = start_q;
   assign bus.o_word     = word_q;
   assign bus.o_len      = len_q;
   assign bus.o_overflow = ovf_q;
   assign bus.o_busy     = busy_q;
   assign bus.o_state    = state_q;
endmodule
